// File: rtl/syn_fifo_prog.sv
// Single-clock FIFO with run-time programmable almost-full/almost-empty offsets,
// fill count, sticky error flags and optional first-word-fall-through read port.
module syn_fifo_prog #(
  parameter  int FIFO_ENTRIES = 16,
  parameter  int DATA_WIDTH   = 8,
  parameter  int FWFT         = 0,
  parameter  int AF_DEFAULT   = 4,
  parameter  int AE_DEFAULT   = 4,
  localparam int AW           = $clog2(FIFO_ENTRIES)
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  cfg_we,
  input  logic                  cfg_sel,
  input  logic [AW-1:0]         cfg_data,
  input  logic                  err_clr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [AW:0]           count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  cfg_err
);

  localparam logic [AW:0]   DEPTH   = (AW+1)'(FIFO_ENTRIES);
  localparam logic [AW-1:0] CFG_MAX = AW'(FIFO_ENTRIES/2 - 1);

  logic [DATA_WIDTH-1:0] mem [FIFO_ENTRIES];

  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic [AW-1:0] x_af_q, x_af_d, x_ae_q, x_ae_d;
  logic          full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
  logic          ovf_q, ovf_d, udf_q, udf_d, cerr_q, cerr_d;
  logic          wr_acc, rd_acc, cfg_ok;

  // Acceptance uses pre-edge flags: full blocks a write even when a read leaves.
  assign wr_acc = wr_en & ~full_q;
  assign rd_acc = rd_en & ~empty_q;
  assign cfg_ok = cfg_we & empty_q & (cfg_data != '0) & (cfg_data <= CFG_MAX);

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_acc);
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_acc);
    count_d  = count_q;
    if (wr_acc && !rd_acc) count_d = count_q + 1'b1;
    if (rd_acc && !wr_acc) count_d = count_q - 1'b1;

    x_af_d = x_af_q;
    x_ae_d = x_ae_q;
    if (cfg_ok) begin
      if (cfg_sel) x_af_d = cfg_data;
      else         x_ae_d = cfg_data;
    end

    full_d  = (count_d == DEPTH);
    empty_d = (count_d == '0);
    af_d    = (count_d >= DEPTH - {1'b0, x_af_d});
    ae_d    = (count_d <= {1'b0, x_ae_d});

    ovf_d  = err_clr ? 1'b0 : (ovf_q  | (wr_en & full_q));
    udf_d  = err_clr ? 1'b0 : (udf_q  | (rd_en & empty_q));
    cerr_d = err_clr ? 1'b0 : (cerr_q | (cfg_we & ~cfg_ok));
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      x_af_q   <= AW'(AF_DEFAULT);
      x_ae_q   <= AW'(AE_DEFAULT);
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      cerr_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      x_af_q   <= x_af_d;
      x_ae_q   <= x_ae_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      cerr_q   <= cerr_d;
    end
  end

  // Storage is never cleared; reset only discards the pointers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst && wr_acc) mem[wr_ptr_q[AW-1:0]] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out   = mem[rd_ptr_q[AW-1:0]];
      assign data_valid = ~empty_q;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  dvld_q;
      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          dout_q <= '0;
          dvld_q <= 1'b0;
        end else begin
          dvld_q <= rd_acc;
          if (rd_acc) dout_q <= mem[rd_ptr_q[AW-1:0]];
        end
      end
      assign data_out   = dout_q;
      assign data_valid = dvld_q;
    end
  endgenerate

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign cfg_err      = cerr_q;

endmodule

// File: tb/tb_syn_fifo_prog.sv
// Directed bench for syn_fifo_prog (16 x 8, registered read): config, fill/drain,
// simultaneous access at the boundaries, sticky errors, pointer wrap and reset.
module tb_syn_fifo_prog;

  logic       clk = 1'b0;
  logic       sys_rst, wr_en, rd_en, cfg_we, cfg_sel, err_clr;
  logic [7:0] data_in, data_out;
  logic [3:0] cfg_data;
  logic [4:0] count;
  logic       data_valid, full, empty, almost_full, almost_empty;
  logic       overflow, underflow, cfg_err;

  int n_checks = 0;
  int n_errors = 0;

  syn_fifo_prog #(
    .FIFO_ENTRIES(16), .DATA_WIDTH(8), .FWFT(0), .AF_DEFAULT(4), .AE_DEFAULT(4)
  ) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(data_out), .data_valid(data_valid),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .err_clr(err_clr),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes; outputs are stable 1 ns after the edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    wr_en = w; data_in = d; rd_en = r;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic cfg(input logic sel, input logic [3:0] val, input logic clr);
    cfg_we = 1'b1; cfg_sel = sel; cfg_data = val; err_clr = clr;
    @(posedge clk); #1;
    cfg_we = 1'b0; err_clr = 1'b0;
  endtask

  task automatic clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  initial begin
    sys_rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_data = '0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 sys_rst = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_dv", 32'(data_valid), 0);
    chk("rst_dout", 32'(data_out), 0);
    chk("rst_sticky", {29'd0, overflow, underflow, cfg_err}, 0);

    // AF offset 3: almost_full from count 13
    cfg(1'b1, 4'd3, 1'b0);
    chk("cfg_af_ok", 32'(cfg_err), 0);
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b1, 8'(k - 1), 1'b0);
      chk($sformatf("fill_count_%0d", k), 32'(count), 32'(k));
      chk($sformatf("fill_af_%0d", k), 32'(almost_full), 32'(k >= 13));
      chk($sformatf("fill_full_%0d", k), 32'(full), 32'(k == 16));
      chk($sformatf("fill_ae_%0d", k), 32'(almost_empty), 32'(k <= 4));
    end
    cyc(1'b1, 8'hEE, 1'b0);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 16);
    chk("no_read_dv", 32'(data_valid), 0);

    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk($sformatf("rd_dv_%0d", i), 32'(data_valid), 1);
      chk($sformatf("rd_data_%0d", i), 32'(data_out), 32'(i));
      chk($sformatf("rd_count_%0d", i), 32'(count), 32'(15 - i));
      chk($sformatf("rd_ae_%0d", i), 32'(almost_empty), 32'((15 - i) <= 4));
    end
    chk("udf_before", 32'(underflow), 0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("udf_set", 32'(underflow), 1);
    chk("udf_dv", 32'(data_valid), 0);
    chk("udf_dout_hold", 32'(data_out), 8'h0F);
    clr();
    chk("clr_sticky", {30'd0, overflow, underflow}, 0);

    // Simultaneous read/write at count 8
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'(8'h28 + i), 1'b1);
      chk($sformatf("rw_count_%0d", i), 32'(count), 8);
      chk($sformatf("rw_data_%0d", i), 32'(data_out), 32'(8'h20 + i));
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk($sformatf("rw_drain_%0d", i), 32'(data_out), 32'(8'h24 + i));
    end
    chk("rw_empty", 32'(empty), 1);

    // Full: only the read goes through
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
    cyc(1'b1, 8'h50, 1'b1);
    chk("full_rw_count", 32'(count), 15);
    chk("full_rw_data", 32'(data_out), 8'h40);
    chk("full_rw_ovf", 32'(overflow), 1);
    chk("full_rw_full", 32'(full), 0);
    clr();
    for (int i = 1; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk($sformatf("full_drain_%0d", i), 32'(data_out), 32'(8'h40 + i));
    end
    // Empty: only the write goes through
    cyc(1'b1, 8'h60, 1'b1);
    chk("empty_rw_count", 32'(count), 1);
    chk("empty_rw_udf", 32'(underflow), 1);
    chk("empty_rw_dv", 32'(data_valid), 0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("empty_rw_data", 32'(data_out), 8'h60);
    chk("empty_rw_cnt0", 32'(count), 0);
    clr();

    // Config rejected while not empty: an accepted AE=6 would raise almost_empty at 5
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h70 + i), 1'b0);
    cfg(1'b0, 4'd6, 1'b0);
    chk("cfg_busy_err", 32'(cfg_err), 1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("cfg_busy_ae", 32'(almost_empty), 0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1);
    clr();
    chk("cfg_clr", 32'(cfg_err), 0);
    cfg(1'b0, 4'd0, 1'b0);
    chk("cfg_zero_err", 32'(cfg_err), 1);
    clr();
    cfg(1'b1, 4'd8, 1'b0);
    chk("cfg_eight_err", 32'(cfg_err), 1);
    cfg(1'b1, 4'd8, 1'b1);
    chk("clr_priority", 32'(cfg_err), 0);
    cfg(1'b0, 4'd7, 1'b0);
    chk("cfg_ae7_ok", 32'(cfg_err), 0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'h00, 1'b0);
    chk("ae7_at7", 32'(almost_empty), 1);
    cyc(1'b1, 8'h00, 1'b0);
    chk("ae7_at8", 32'(almost_empty), 0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("ae7_empty", 32'(empty), 1);

    // 40-word stream, wraps pointers more than twice
    cyc(1'b1, 8'h80, 1'b0);
    for (int i = 1; i < 40; i++) begin
      cyc(1'b1, 8'(8'h80 + i), 1'b1);
      chk($sformatf("stream_%0d", i - 1), 32'(data_out), 32'(8'h80 + i - 1));
    end
    chk("stream_count", 32'(count), 1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("stream_last", 32'(data_out), 8'hA7);
    chk("stream_empty", 32'(empty), 1);

    for (int i = 0; i < 7; i++) cyc(1'b1, 8'h00, 1'b0);
    chk("pre_rst_count", 32'(count), 7);
    sys_rst = 1'b1;
    @(posedge clk); #1;
    sys_rst = 1'b0;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_dv", 32'(data_valid), 0);
    // AF offset back to 4: almost_full at 12, not at 11
    for (int i = 0; i < 11; i++) cyc(1'b1, 8'h00, 1'b0);
    chk("rst_af_11", 32'(almost_full), 0);
    cyc(1'b1, 8'h00, 1'b0);
    chk("rst_af_12", 32'(almost_full), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
